multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max memory-wait count before fault (4-bit counter).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port i_instr  input  32  instruction word from imem, sampled on i_imem_ack.
REQ-005 SHALL have port i_imem_ack  input  1  instruction fetch complete.
REQ-006 SHALL have port i_dmem_ack  input  1  data access complete.
REQ-007 SHALL have port i_br_taken  input  1  branch comparator result, valid in EXEC/WB.
REQ-008 SHALL have ports o_imem_req, o_dmem_req, o_dmem_wren  output  1 each  memory requests; wren=1 store.
REQ-009 SHALL have ports o_ir_en, o_pc_en  output  1 each  IR load strobe, PC update strobe.
REQ-010 SHALL have port o_pc_sel  output  1  0=PC+4, 1=ALU result.
REQ-011 SHALL have port o_opa_sel  output  2  00=rs1, 01=PC, 10=zero.
REQ-012 SHALL have port o_opb_sel  output  1  0=rs2, 1=immediate.
REQ-013 SHALL have ports o_rd_wren (1), o_wb_sel (2: 00=ALU, 01=mem, 10=PC+4)  outputs  register writeback control.
REQ-014 SHALL have ports o_insn_vld (1, retire pulse), o_fault (1, sticky), o_state (3, debug)  outputs.

Function
REQ-015 SHALL implement FSM FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; all outputs Moore-decoded from state plus latched opcode.
REQ-016 FETCH: o_imem_req=1; on i_imem_ack latch i_instr[6:0], pulse o_ir_en, go DECODE.
REQ-017 DECODE: one cycle; legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC; any other -> HALT.
REQ-018 EXEC: one cycle; load/store -> MEM, all others -> WB.
REQ-019 MEM: o_dmem_req=1, o_dmem_wren=1 for store only; on ack: load -> WB; store -> pulse o_pc_en (o_pc_sel=0), o_insn_vld, go FETCH.
REQ-020 WB: o_pc_en=1; o_pc_sel=jal|jalr|(branch&i_br_taken); o_rd_wren=1 except branch/store; o_wb_sel=10 for jal/jalr, 01 for load, else 00; pulse o_insn_vld; go FETCH.
REQ-021 o_opa_sel SHALL be 01 for branch/jal/auipc, 10 for lui, 00 otherwise; o_opb_sel=0 only for opcode 0110011; both held stable in EXEC, MEM, WB, 00/0 elsewhere.
REQ-022 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle without ack; no ack while count==TIMEOUT -> HALT; ack at count==TIMEOUT is accepted.
REQ-023 HALT: o_fault=1, all strobes/requests 0; exits only via reset.
REQ-024 Acks outside FETCH/MEM SHALL be ignored; i_dmem_ack in FETCH and i_imem_ack in MEM likewise.
REQ-025 Latency with zero-wait acks: ALU/lui/auipc/jal/jalr/branch/store 4 cycles FETCH-to-retire-inclusive; load 5 cycles.

Reset
REQ-026 While i_reset=0 at a clock edge, state SHALL become FETCH, counter and latched opcode 0, o_fault 0.
REQ-027 During reset all outputs SHALL be 0 (o_state=0); first o_imem_req one cycle after i_reset rises-sampled high.
REQ-028 Reset asserted mid-MEM/WB SHALL suppress o_pc_en, o_rd_wren, o_insn_vld from the next edge onward.

Structure
REQ-029 State enum, opcode constants, opa/wb_sel encodings SHALL live in shared package ctrl_pkg.
REQ-030 Opcode-to-class flags (is_branch, is_jal, is_jalr, is_lui, is_auipc, is_load, is_store, is_rtype, legal) SHALL be one combinational sub-module ctrl_decode.

Verification
REQ-031 ADDI 0x00500093, immediate acks -> o_insn_vld on 4th cycle, o_rd_wren=1, o_wb_sel=00, o_opa_sel=00, o_opb_sel=1.
REQ-032 AUIPC 0x00001097 -> o_opa_sel=01 in EXEC and WB, o_rd_wren=1, o_pc_sel=0; LUI 0x000010B7 -> o_opa_sel=10.
REQ-033 LW 0x0000A103, i_dmem_ack after 3 wait cycles -> o_dmem_req high 4 cycles, o_dmem_wren=0, then WB with o_wb_sel=01, retire on cycle 8.
REQ-034 BEQ 0x00000463 with i_br_taken=1 -> o_pc_sel=1, o_pc_en=1, o_rd_wren=0; repeat with 0 -> o_pc_sel=0.
REQ-035 TIMEOUT=15: i_imem_ack withheld 16 cycles -> o_fault=1, o_state=7; ack on 16th cycle -> DECODE, no fault.
REQ-036 Opcode 0x0000007F -> HALT after DECODE, o_fault=1; i_reset=0 during MEM of SW -> no o_insn_vld, o_state=0 next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Package : ctrl_pkg
// Brief   : State codes, RV32I opcodes, operand/writeback encodings for the
//           multicycle control FSM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic is_load;
    logic is_store;
    logic is_rtype;
    logic legal;
  } op_class_t;

  function automatic logic [1:0] opa_sel_of(input op_class_t c);
    if (c.is_branch || c.is_jal || c.is_auipc) return OPA_PC;
    if (c.is_lui) return OPA_ZERO;
    return OPA_RS1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module : ctrl_decode
// Brief  : Combinational opcode-to-class flags for the control FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_cls
);

  always_comb begin
    o_cls       = '0;
    o_cls.legal = 1'b1;
    case (i_opcode)
      OP_RTYPE:  o_cls.is_rtype  = 1'b1;
      OP_IMM:    o_cls.legal     = 1'b1;
      OP_LOAD:   o_cls.is_load   = 1'b1;
      OP_STORE:  o_cls.is_store  = 1'b1;
      OP_BRANCH: o_cls.is_branch = 1'b1;
      OP_JAL:    o_cls.is_jal    = 1'b1;
      OP_JALR:   o_cls.is_jalr   = 1'b1;
      OP_LUI:    o_cls.is_lui    = 1'b1;
      OP_AUIPC:  o_cls.is_auipc  = 1'b1;
      default:   o_cls.legal     = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multicycle RV32I control FSM with memory-wait timeout and fault.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  input  logic        i_br_taken,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_dmem_wren,
  output logic        o_ir_en,
  output logic        o_pc_en,
  output logic        o_pc_sel,
  output logic [1:0]  o_opa_sel,
  output logic        o_opb_sel,
  output logic        o_rd_wren,
  output logic [1:0]  o_wb_sel,
  output logic        o_insn_vld,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  localparam logic [3:0] C_TIMEOUT = 4'(TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] op_q, op_d;
  logic       fault_q, fault_d;
  logic       run_q, run_d;
  op_class_t  cls;

  logic w_unused_instr;
  assign w_unused_instr = ^i_instr[31:7];

  ctrl_decode u_decode (
    .i_opcode (op_q),
    .o_cls    (cls)
  );

  // run_q holds everything quiet for the first cycle after reset is released
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    op_d    = op_q;
    run_d   = 1'b1;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          if (i_imem_ack) begin
            op_d    = i_instr[6:0];
            state_d = ST_DECODE;
          end else if (cnt_q == C_TIMEOUT) begin
            state_d = ST_HALT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_DECODE: state_d = cls.legal ? ST_EXEC : ST_HALT;
        ST_EXEC:   state_d = (cls.is_load || cls.is_store) ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (i_dmem_ack) begin
            state_d = cls.is_store ? ST_FETCH : ST_WB;
          end else if (cnt_q == C_TIMEOUT) begin
            state_d = ST_HALT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_WB:     state_d = ST_FETCH;
        ST_HALT:   state_d = ST_HALT;
        default:   state_d = ST_HALT;
      endcase
    end
    fault_d = fault_q | (state_d == ST_HALT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= 4'd0;
      op_q    <= 7'd0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fault_q <= fault_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_wren = 1'b0;
    o_ir_en     = 1'b0;
    o_pc_en     = 1'b0;
    o_pc_sel    = 1'b0;
    o_opa_sel   = OPA_RS1;
    o_opb_sel   = 1'b0;
    o_rd_wren   = 1'b0;
    o_wb_sel    = WB_ALU;
    o_insn_vld  = 1'b0;
    o_fault     = fault_q;
    o_state     = state_q;
    if (run_q) begin
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        o_opa_sel = opa_sel_of(cls);
        o_opb_sel = ~cls.is_rtype;
      end
      case (state_q)
        ST_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_en    = i_imem_ack;
        end
        ST_MEM: begin
          o_dmem_req  = 1'b1;
          o_dmem_wren = cls.is_store;
          if (i_dmem_ack && cls.is_store) begin
            o_pc_en    = 1'b1;
            o_insn_vld = 1'b1;
          end
        end
        ST_WB: begin
          o_pc_en    = 1'b1;
          o_pc_sel   = cls.is_jal | cls.is_jalr | (cls.is_branch & i_br_taken);
          o_rd_wren  = ~(cls.is_branch | cls.is_store);
          o_wb_sel   = (cls.is_jal || cls.is_jalr) ? WB_PC4 :
                       (cls.is_load ? WB_MEM : WB_ALU);
          o_insn_vld = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Scoreboard bench for multicycle_ctrl with directed instructions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic        i_clk, i_reset;
  logic [31:0] i_instr;
  logic        i_imem_ack, i_dmem_ack, i_br_taken;
  logic        o_imem_req, o_dmem_req, o_dmem_wren, o_ir_en, o_pc_en, o_pc_sel;
  logic [1:0]  o_opa_sel;
  logic        o_opb_sel, o_rd_wren;
  logic [1:0]  o_wb_sel;
  logic        o_insn_vld, o_fault;
  logic [2:0]  o_state;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr),
    .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack), .i_br_taken(i_br_taken),
    .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_dmem_wren(o_dmem_wren),
    .o_ir_en(o_ir_en), .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel),
    .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_rd_wren(o_rd_wren),
    .o_wb_sel(o_wb_sel), .o_insn_vld(o_insn_vld), .o_fault(o_fault),
    .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam int K_RETIRE = 0;
  localparam int K_FAULT  = 1;
  localparam int K_RESET  = 2;

  typedef struct {
    int         kind;
    logic       pc_sel;
    logic       rd_wren;
    logic [1:0] wb_sel;
    logic [1:0] opa;
    logic       opb;
    int         lat;
    int         dreq;
    logic       wren;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ret(input logic pc_sel, input logic rd, input logic [1:0] wb,
                          input logic [1:0] opa, input logic opb, input int lat,
                          input int dreq, input logic wren);
    exp_t e;
    e.kind = K_RETIRE; e.pc_sel = pc_sel; e.rd_wren = rd; e.wb_sel = wb;
    e.opa = opa; e.opb = opb; e.lat = lat; e.dreq = dreq; e.wren = wren;
    sbq.push_back(e);
  endtask

  task automatic push_evt(input int kind, input int lat);
    exp_t e;
    e.kind = kind; e.pc_sel = 1'b0; e.rd_wren = 1'b0; e.wb_sel = 2'b00;
    e.opa = 2'b00; e.opb = 1'b0; e.lat = lat; e.dreq = 0; e.wren = 1'b0;
    sbq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic       samp_rst = 1'b1;
  logic       in_run   = 1'b1;
  logic       prev_fault = 1'b0;
  int         lat = 0, dreq = 0;
  logic       wren_seen = 1'b0;
  logic [1:0] exec_opa = 2'b00;
  logic       exec_opb = 1'b0;

  always @(posedge i_clk) samp_rst = i_reset;

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1;
    if (sbq.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = sbq.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    bit   ok;
    if (!samp_rst) begin
      if (in_run) begin
        pop_exp(K_RESET, e, ok);
        if (ok) begin
          chk("rst_outputs", int'({o_imem_req, o_dmem_req, o_dmem_wren, o_ir_en, o_pc_en,
              o_pc_sel, o_opa_sel, o_opb_sel, o_rd_wren, o_wb_sel, o_insn_vld, o_fault}), 0);
          chk("rst_state", int'(o_state), 0);
        end
      end
      in_run = 1'b0;
      lat = 0; dreq = 0; wren_seen = 1'b0; exec_opa = 2'b00; exec_opb = 1'b0;
    end else begin
      in_run = 1'b1;
      if (o_state == 3'd2) begin
        exec_opa = o_opa_sel;
        exec_opb = o_opb_sel;
      end
      if (o_dmem_req) dreq++;
      wren_seen = wren_seen | o_dmem_wren;
      if ((o_state != 3'd0 || o_imem_req) && o_state != 3'd7) lat++;
      if (o_insn_vld) begin
        pop_exp(K_RETIRE, e, ok);
        if (ok) begin
          chk("pc_en",        int'(o_pc_en), 1);
          chk("pc_sel",       int'(o_pc_sel), int'(e.pc_sel));
          chk("rd_wren",      int'(o_rd_wren), int'(e.rd_wren));
          chk("wb_sel",       int'(o_wb_sel), int'(e.wb_sel));
          chk("opa_sel_ret",  int'(o_opa_sel), int'(e.opa));
          chk("opa_sel_exec", int'(exec_opa), int'(e.opa));
          chk("opb_sel",      int'(o_opb_sel), int'(e.opb));
          chk("opb_sel_exec", int'(exec_opb), int'(e.opb));
          chk("latency",      lat, e.lat);
          chk("dmem_req_cyc", dreq, e.dreq);
          chk("dmem_wren",    int'(wren_seen), int'(e.wren));
        end
        lat = 0; dreq = 0; wren_seen = 1'b0;
      end
      if (o_fault && !prev_fault) begin
        pop_exp(K_FAULT, e, ok);
        if (ok) begin
          chk("fault_state",   int'(o_state), 7);
          chk("fault_strobes", int'({o_imem_req, o_dmem_req, o_ir_en, o_pc_en,
                                     o_rd_wren, o_insn_vld}), 0);
          chk("fault_latency", lat, e.lat);
        end
        lat = 0; dreq = 0; wren_seen = 1'b0;
      end
    end
    prev_fault = o_fault;
  end

  // ---------------- drivers (enter and leave just after a posedge) ----------------
  task automatic do_fetch(input logic [31:0] instr, input int wait_n);
    int cnt = 0, guard = 0;
    bit done = 1'b0;
    while (!done) begin
      if (o_fault) begin
        done = 1'b1;
      end else if (o_imem_req && cnt == wait_n) begin
        i_instr = instr; i_imem_ack = 1'b1;
        @(posedge i_clk); #1;
        i_imem_ack = 1'b0;
        done = 1'b1;
      end else begin
        if (o_imem_req) cnt++;
        guard++;
        if (guard > 100) begin
          n_tests++; n_fail++;
          $display("FAIL fetch_wait: got no imem_req/fault within 100 cycles expected one");
          done = 1'b1;
        end else begin
          @(posedge i_clk); #1;
        end
      end
    end
  endtask

  task automatic do_mem(input int wait_n, input bit noise);
    int cnt = 0, guard = 0;
    bit done = 1'b0;
    if (noise) i_imem_ack = 1'b1;
    while (!done) begin
      if (o_dmem_req && cnt == wait_n) begin
        i_dmem_ack = 1'b1;
        @(posedge i_clk); #1;
        i_dmem_ack = 1'b0;
        done = 1'b1;
      end else begin
        if (o_dmem_req) cnt++;
        guard++;
        if (guard > 100) begin
          n_tests++; n_fail++;
          $display("FAIL mem_wait: got no dmem_req within 100 cycles expected one");
          done = 1'b1;
        end else begin
          @(posedge i_clk); #1;
        end
      end
    end
    i_imem_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    push_evt(K_RESET, 0);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_reset = 1'b0; i_instr = 32'd0; i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0; i_br_taken = 1'b0;
    push_evt(K_RESET, 0);
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b1;

    // fields: pc_sel rd_wren wb_sel opa opb latency dreq wren
    push_ret(0, 1, 2'b00, 2'b00, 1, 4, 0, 0); do_fetch(32'h00500093, 0); // ADDI
    push_ret(0, 1, 2'b00, 2'b01, 1, 4, 0, 0); do_fetch(32'h00001097, 0); // AUIPC
    push_ret(0, 1, 2'b00, 2'b10, 1, 4, 0, 0); do_fetch(32'h000010B7, 0); // LUI
    push_ret(0, 1, 2'b00, 2'b00, 0, 4, 0, 0); do_fetch(32'h002081B3, 0); // ADD
    push_ret(0, 1, 2'b01, 2'b00, 1, 8, 4, 0); do_fetch(32'h0000A103, 0); // LW
    do_mem(3, 1'b1);
    push_ret(0, 0, 2'b00, 2'b00, 1, 4, 1, 1); do_fetch(32'h0020A023, 0); // SW
    do_mem(0, 1'b0);
    i_br_taken = 1'b1;
    push_ret(1, 0, 2'b00, 2'b01, 1, 4, 0, 0); do_fetch(32'h00000463, 0); // BEQ taken
    idle(3);
    i_br_taken = 1'b0;
    push_ret(0, 0, 2'b00, 2'b01, 1, 4, 0, 0); do_fetch(32'h00000463, 0); // BEQ not taken
    push_ret(1, 1, 2'b10, 2'b01, 1, 4, 0, 0); do_fetch(32'h008000EF, 0); // JAL
    push_ret(1, 1, 2'b10, 2'b00, 1, 4, 0, 0); do_fetch(32'h000080E7, 0); // JALR

    // fetch accepted exactly at the timeout count, stray dmem ack ignored
    i_dmem_ack = 1'b1;
    push_ret(0, 1, 2'b00, 2'b00, 1, 19, 0, 0); do_fetch(32'h00500093, 15);
    idle(3);
    i_dmem_ack = 1'b0;

    // fetch ack withheld past the timeout
    push_evt(K_FAULT, 16); do_fetch(32'h00500093, 1000);
    idle(2);
    pulse_reset();

    // illegal opcode
    push_evt(K_FAULT, 2); do_fetch(32'h0000007F, 0);
    idle(3);
    pulse_reset();

    // reset in the middle of a store's MEM phase
    push_evt(K_RESET, 0);
    do_fetch(32'h0020A023, 0);
    for (int g = 0; g < 10 && !o_dmem_req; g++) idle(1);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;

    push_ret(0, 1, 2'b00, 2'b00, 1, 4, 0, 0); do_fetch(32'h00500093, 0); // recovery
    for (int g = 0; g < 50 && sbq.size() != 0; g++) idle(1);
    idle(2);
    chk("queue_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
